// File: rtl/register_file_pkg.sv
// Shared defaults and word type for the architectural register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_file_pkg;

  localparam int DEF_XLEN    = 32;  // register / data width in bits
  localparam int DEF_NREGS   = 32;  // number of architectural registers
  localparam int DEF_ADDR_W  = 5;   // log2(DEF_NREGS)
  localparam int DEF_TAP_REG = 10;  // x10 / a0, mirrored on the debug tap

  typedef logic [DEF_XLEN-1:0] word_t;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Flip-flop register file: NREGS x XLEN, two gated read ports, one write port, x0 hardwired to 0.
// Latency: reads combinational (zero cycles); a write is visible after the rising edge that captures it.
// Backpressure: none; every enabled write is accepted and reads are always available.
//
// Ports:
//   clk            sole clock, all state updates on the rising edge
//   reset          synchronous active-low clear of every register
//   read_enable    gates both read ports; when low both data outputs drive 0
//   write_enable   write strobe for the write port
//   read_addr1/2   read port register indices
//   write_addr     write port register index (address 0 discards the write)
//   write_data     data to write
//   data_out1/2    read port data
//   a              continuous tap of register TAP_REG, independent of read_enable
module register_file
  import register_file_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREGS   = DEF_NREGS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TAP_REG = DEF_TAP_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   data_out1,
  output logic [XLEN-1:0]   data_out2,
  output logic [XLEN-1:0]   a
);

  logic [XLEN-1:0] regs [NREGS];

  // Reset has priority over a simultaneous write. Entry 0 is only ever
  // written by reset, and the read side masks it as well, so x0 reads 0
  // even before the first reset edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // No write-to-read bypass: reads see the array contents as of the last edge.
  always_comb begin
    data_out1 = '0;
    data_out2 = '0;
    if (read_enable) begin
      if (read_addr1 != '0) data_out1 = regs[read_addr1];
      if (read_addr2 != '0) data_out2 = regs[read_addr2];
    end
  end

  if (TAP_REG == 0) begin : g_tap_zero
    assign a = '0;
  end else begin : g_tap_reg
    assign a = regs[TAP_REG];
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with a queue-based scoreboard.
// Latency: expectations are pushed as stimulus is driven and popped when outputs settle.
// Backpressure: n/a.
module tb_register_file;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [ADDR_W-1:0] write_addr;
  logic [XLEN-1:0]   write_data;
  logic [XLEN-1:0]   data_out1;
  logic [XLEN-1:0]   data_out2;
  logic [XLEN-1:0]   a;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] exp_q [$];

  register_file #(
    .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .TAP_REG(10)
  ) dut (
    .clk(clk), .reset(reset), .read_enable(read_enable),
    .write_enable(write_enable), .read_addr1(read_addr1),
    .read_addr2(read_addr2), .write_addr(write_addr),
    .write_data(write_data), .data_out1(data_out1),
    .data_out2(data_out2), .a(a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs);
    logic [XLEN-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b1;
    read_addr1   = '0;
    read_addr2   = '0;
    write_addr   = 5'd5;
    write_data   = 32'hFFFF_FFFF;

    // Reset for one edge (with a write pending that must be ignored).
    tick();
    reset        = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      read_addr1 = ADDR_W'(i);
      read_addr2 = ADDR_W'(NREGS - 1 - i);
      push('0); push('0);
      #1;
      check("reset_rd1", data_out1);
      check("reset_rd2", data_out2);
    end
    push('0);
    check("reset_tap", a);

    // Write i to register i.
    write_enable = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      write_addr = ADDR_W'(i);
      write_data = XLEN'(i);
      tick();
    end
    write_enable = 1'b0;

    read_addr1 = 5'd0; read_addr2 = 5'd1;
    push(32'd0); push(32'd1);
    #1;
    check("x0_read", data_out1);
    check("x1_read", data_out2);
    read_addr2 = 5'd30;
    push(32'd30);
    #1;
    check("x30_read", data_out2);
    for (int i = 0; i < NREGS; i++) begin
      read_addr1 = ADDR_W'(i);
      read_addr2 = ADDR_W'(i);
      push(XLEN'(i)); push(XLEN'(i));
      #1;
      check("fill_rd1", data_out1);
      check("fill_rd2_same_addr", data_out2);
    end
    push(32'h0000_000A);
    check("tap_after_fill", a);

    // Read gating leaves the tap alone.
    read_enable = 1'b0;
    read_addr1 = 5'd12; read_addr2 = 5'd13;
    push('0); push('0); push(32'h0000_000A);
    #1;
    check("rden0_rd1", data_out1);
    check("rden0_rd2", data_out2);
    check("rden0_tap", a);
    read_enable = 1'b1;

    // write_enable=0 must not write.
    write_enable = 1'b0; write_addr = 5'd5; write_data = 32'hDEAD_BEEF;
    tick();
    read_addr1 = 5'd5;
    push(32'd5);
    #1;
    check("wen0_hold", data_out1);

    // Writes to x0 are discarded.
    write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF_FFFF;
    tick();
    write_enable = 1'b0;
    read_addr1 = 5'd0;
    push('0);
    #1;
    check("x0_discard", data_out1);

    // No bypass: old value before the edge, new value after.
    read_addr1 = 5'd7; read_addr2 = 5'd7;
    write_enable = 1'b1; write_addr = 5'd7; write_data = 32'h1234_5678;
    push(32'd7); push(32'd7);
    #1;
    check("nobypass_pre_rd1", data_out1);
    check("nobypass_pre_rd2", data_out2);
    tick();
    write_enable = 1'b0;
    push(32'h1234_5678); push(32'h1234_5678);
    check("nobypass_post_rd1", data_out1);
    check("nobypass_post_rd2", data_out2);

    // Writing the tap register updates a.
    write_enable = 1'b1; write_addr = 5'd10; write_data = 32'hCAFE_0010;
    tick();
    write_enable = 1'b0;
    push(32'hCAFE_0010);
    check("tap_update", a);

    // Mid-operation reset with a simultaneous write to x3.
    reset = 1'b0;
    write_enable = 1'b1; write_addr = 5'd3; write_data = 32'hAAAA_5555;
    tick();
    reset = 1'b1;
    write_enable = 1'b0;
    read_addr1 = 5'd3; read_addr2 = 5'd7;
    push('0); push('0); push('0);
    #1;
    check("rst_write_ignored", data_out1);
    check("rst_clears_x7", data_out2);
    check("rst_clears_tap", a);

    // Reset pulsed low between edges must have no effect.
    write_enable = 1'b1; write_addr = 5'd10; write_data = 32'h0000_0055;
    tick();
    write_enable = 1'b0;
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    read_addr1 = 5'd10;
    push(32'h0000_0055); push(32'h0000_0055);
    #1;
    check("sync_reset_tap", a);
    check("sync_reset_rd1", data_out1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
